// File: rtl/hex_ctrl_pkg.sv
// Shared types and constants for the seven-segment display controller.
//   digit_t  : per-digit state (hex nibble, dark flag, blink flag)
//   SEG_OFF  : active-low pattern with every segment dark
//   IDX_W    : width of a requester's digit index
package hex_ctrl_pkg;

   typedef struct packed {
      logic [3:0] value;
      logic       blank;
      logic       blink;
   } digit_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam int         IDX_W   = 3;

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low seven-segment decoder (purely combinational).
// Ports:
//   value  in  4  hex nibble
//   seg    out 7  segments {g,f,e,d,c,b,a}, 0 = lit
module hex7seg (
   input  logic [3:0] value,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'h7F;
      case (value)
         4'h0: seg = 7'b100_0000;
         4'h1: seg = 7'b111_1001;
         4'h2: seg = 7'b010_0100;
         4'h3: seg = 7'b011_0000;
         4'h4: seg = 7'b001_1001;
         4'h5: seg = 7'b001_0010;
         4'h6: seg = 7'b000_0010;
         4'h7: seg = 7'b111_1000;
         4'h8: seg = 7'b000_0000;
         4'h9: seg = 7'b001_0000;
         4'hA: seg = 7'b000_1000;
         4'hB: seg = 7'b000_0011;
         4'hC: seg = 7'b100_0110;
         4'hD: seg = 7'b010_0001;
         4'hE: seg = 7'b000_0110;
         4'hF: seg = 7'b000_1110;
         default: seg = 7'h7F;
      endcase
   end

endmodule

// File: rtl/hex_display_ctrl.sv
// Seven-segment bank shared between NREQ requesters.
// Each requester writes one digit (value/blank/blink) through valid/ready;
// a round-robin arbiter grants at most one write per cycle. The block holds
// the digit state, runs the blink timebase and drives registered active-low
// segments.
// Ports:
//   clk        in   1          system clock
//   reset      in   1          synchronous, active-high
//   req_valid  in   NREQ       write request per requester
//   req_ready  out  NREQ       grant, one-hot or zero (combinational)
//   req_digit  in   NREQ*3     digit index, slice i = [3i+2:3i]
//   req_value  in   NREQ*4     hex nibble, slice i = [4i+3:4i]
//   req_blank  in   NREQ       1 = digit dark
//   req_blink  in   NREQ       1 = digit blinks
//   bad_index  out  1          pulse after an accepted write to a missing digit
//   hex        out  NDIGITS*7  segments, active-low, digit d = [7d+6:7d]
module hex_display_ctrl
   import hex_ctrl_pkg::*;
#(
   parameter int NREQ      = 2,
   parameter int NDIGITS   = 6,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*IDX_W-1:0]  req_digit,
   input  logic [NREQ*4-1:0]      req_value,
   input  logic [NREQ-1:0]        req_blank,
   input  logic [NREQ-1:0]        req_blink,
   output logic                   bad_index,
   output logic [NDIGITS*7-1:0]   hex
);

   localparam int PW    = (NREQ > 2) ? 2 : 1;
   localparam int CNT_W = $clog2(BLINK_DIV);

   logic [PW-1:0]    ptr;
   logic [PW-1:0]    gnt_idx;
   logic             found;
   logic             xfer;
   logic [IDX_W-1:0] r_digit [NREQ];
   logic [3:0]       r_value [NREQ];
   logic [IDX_W-1:0] sel_digit;
   digit_t           sel_data;

   digit_t           dig [NDIGITS];
   logic [6:0]       seg_raw [NDIGITS];
   logic [NDIGITS*7-1:0] hex_next;

   logic [CNT_W-1:0] blink_cnt;
   logic             phase_on;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign r_digit[g] = req_digit[g*IDX_W +: IDX_W];
      assign r_value[g] = req_value[g*4 +: 4];
   end

   // First valid requester at or after the pointer, scanning upward with wrap.
   always_comb begin
      req_ready = '0;
      gnt_idx   = '0;
      found     = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         int tmp;
         tmp = int'(ptr) + k;
         if (tmp >= NREQ) tmp = tmp - NREQ;
         if (!found && req_valid[tmp[PW-1:0]]) begin
            found   = 1'b1;
            gnt_idx = tmp[PW-1:0];
         end
      end
      if (found && !reset) req_ready[gnt_idx] = 1'b1;
   end

   assign xfer            = |req_ready;
   assign sel_digit       = r_digit[gnt_idx];
   assign sel_data.value  = r_value[gnt_idx];
   assign sel_data.blank  = req_blank[gnt_idx];
   assign sel_data.blink  = req_blink[gnt_idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr       <= '0;
         bad_index <= 1'b0;
         for (int d = 0; d < NDIGITS; d++) begin
            dig[d] <= '{value: 4'h0, blank: 1'b1, blink: 1'b0};
         end
      end else begin
         bad_index <= xfer && (int'(sel_digit) >= NDIGITS);
         if (xfer) begin
            ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
         end
         for (int d = 0; d < NDIGITS; d++) begin
            if (xfer && int'(sel_digit) == d) dig[d] <= sel_data;
         end
      end
   end

   // Free-running blink timebase; phase flips each time the count wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt <= '0;
         phase_on  <= 1'b1;
      end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
         blink_cnt <= '0;
         phase_on  <= ~phase_on;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   for (genvar d = 0; d < NDIGITS; d++) begin : g_digit
      hex7seg u_dec (
         .value (dig[d].value),
         .seg   (seg_raw[d])
      );
      assign hex_next[d*7 +: 7] =
         (dig[d].blank || (dig[d].blink && !phase_on)) ? SEG_OFF : seg_raw[d];
   end

   always_ff @(posedge clk) begin
      if (reset) hex <= '1;
      else       hex <= hex_next;
   end

endmodule
